fetch_prefetch_unit: RTL and testbench

- Instruction-fetch front end that feeds the decode stage of the pipelined core.
- Issues sequential word fetches to instruction memory over a valid/ready request channel and accepts in-order responses of arbitrary latency.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode with valid/ready.
- Flushes and re-steers on a branch redirect from the execute stage, discarding stale in-flight responses.

---
 rtl/fetch_prefetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: sequential word prefetch into a small {pc, instr} FIFO
// feeding decode, with branch redirect that flushes the FIFO and drops stale responses.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] in_flight_reg;
  logic [CW-1:0] drop_cnt_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [CW:0]   occupancy;
  logic          space_avail;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] req_inc;
  logic [CW-1:0] rsp_dec;
  logic [CW-1:0] push_inc;
  logic [CW-1:0] pop_dec;
  logic [31:0]   redirect_target;

  // In-flight requests reserve FIFO slots, so a response can always be pushed.
  assign occupancy   = {1'b0, count_reg} + {1'b0, in_flight_reg};
  assign space_avail = occupancy < DEPTH_C;

  assign imem_req_valid = rst_n && !redirect_valid && space_avail;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = imem_rsp_valid && (in_flight_reg != '0);
  assign rsp_drop = rsp_fire && (drop_cnt_reg != '0);
  assign push     = rsp_fire && !rsp_drop && !redirect_valid;

  assign if_valid = (count_reg != '0);
  assign pop      = if_valid && if_ready && !redirect_valid;
  assign if_pc    = if_valid ? pc_mem[rd_ptr_reg]    : 32'd0;
  assign if_instr = if_valid ? instr_mem[rd_ptr_reg] : 32'd0;

  assign req_inc  = {{(CW-1){1'b0}}, req_fire};
  assign rsp_dec  = {{(CW-1){1'b0}}, rsp_fire};
  assign push_inc = {{(CW-1){1'b0}}, push};
  assign pop_dec  = {{(CW-1){1'b0}}, pop};

  assign redirect_target = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg  <= RESET_PC;
      rsp_pc_reg    <= RESET_PC;
      count_reg     <= '0;
      in_flight_reg <= '0;
      drop_cnt_reg  <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
    end else if (redirect_valid) begin
      // Every outstanding request, including already-pending drops, becomes stale.
      fetch_pc_reg  <= redirect_target;
      rsp_pc_reg    <= redirect_target;
      count_reg     <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      in_flight_reg <= in_flight_reg - rsp_dec;
      drop_cnt_reg  <= in_flight_reg - rsp_dec;
    end else begin
      if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      if (push) begin
        rsp_pc_reg <= rsp_pc_reg + 32'd4;
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (rsp_drop) begin
        drop_cnt_reg <= drop_cnt_reg - CNT_ONE;
      end
      count_reg     <= count_reg + push_inc - pop_dec;
      in_flight_reg <= in_flight_reg + req_inc - rsp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
      instr_mem[wr_ptr_reg] <= imem_rsp_data;
    end
  end

  rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (in_flight_reg == '0)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised scoreboard bench for fetch_prefetch_unit: expected {pc, instr} stream and
// request flow control come from a queue-based model of fetch, redirect and reset rules.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } mem_ent_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_ent_t;

  mem_ent_t    mem_q[$];
  exp_ent_t    exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          buffered = 0;
  int          pops = 0;
  int          fixed_lat = 1;
  int          first_hs = -1;
  int          first_valid = -1;
  logic [31:0] next_fetch = RESET_PC;
  logic [31:0] last_pop_pc = 32'd0;
  logic [31:0] last_pop_instr = 32'd0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: in-order responses, each at least one cycle after its request.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(mem_q[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  mem_ent_t m_ent;
  exp_ent_t e_ent;
  logic     exp_valid_b;
  logic     exp_req_b;
  int       lat;

  always @(negedge clk) begin
    exp_valid_b = (buffered != 0);
    chk("if_valid", 32'(if_valid), 32'(exp_valid_b));
    if (!exp_valid_b) begin
      chk("if_pc_empty", if_pc, 32'd0);
      chk("if_instr_empty", if_instr, 32'd0);
    end
    if (!rst_n) begin
      chk("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
      mem_q.delete();
      exp_q.delete();
      buffered    = 0;
      next_fetch  = RESET_PC;
      first_hs    = -1;
      first_valid = -1;
    end else begin
      exp_req_b = !redirect_valid && (buffered + int'(mem_q.size()) < int'(DEPTH));
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req_b));
      if (if_valid && first_valid < 0) first_valid = cyc;
      if (imem_rsp_valid && mem_q.size() > 0) begin
        m_ent = mem_q.pop_front();
        if (!m_ent.stale && !redirect_valid) buffered++;
      end
      if (if_valid && if_ready && !redirect_valid) begin
        chk("model_has_entry_on_pop", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e_ent = exp_q.pop_front();
          chk("pop_pc", if_pc, e_ent.pc);
          chk("pop_instr", if_instr, e_ent.instr);
          $display("pop pc=%08h instr=%08h", if_pc, if_instr);
          last_pop_pc    = if_pc;
          last_pop_instr = if_instr;
          buffered--;
          pops++;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, next_fetch);
        exp_q.push_back('{pc: next_fetch, instr: word_at(next_fetch)});
        lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat, stale: 1'b0});
        next_fetch = next_fetch + 32'd4;
        if (first_hs < 0) first_hs = cyc;
      end
      if (redirect_valid) begin
        exp_q.delete();
        buffered = 0;
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        next_fetch = redirect_pc & ~32'h0000_0003;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_first_pop(input string name, input logic [31:0] pc);
    int p0;
    int n;
    p0 = pops;
    n  = 0;
    while (pops == p0 && n < 60) begin
      next_cycle();
      n++;
    end
    chk({name, "_pc"}, last_pop_pc, pc);
    chk({name, "_instr"}, last_pop_instr, word_at(pc));
  endtask

  initial begin
    int n;
    int p0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    fixed_lat      = 1;

    // Reset state, observed while rst_n is still low.
    next_cycle();
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Streaming with 1-cycle memory: latency 2, then one instruction per cycle.
    repeat (10) next_cycle();
    chk("first_latency", 32'(first_valid - first_hs), 32'd2);
    p0 = pops;
    repeat (20) next_cycle();
    chk("throughput", 32'(pops - p0), 32'd20);

    // Decode stall fills exactly DEPTH entries.
    if_ready = 1'b0;
    repeat (10) next_cycle();
    #2;
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_if_valid", 32'(if_valid), 32'd1);
    chk("stall_buffered", 32'(buffered), 32'(DEPTH));
    if_ready = 1'b1;
    repeat (10) next_cycle();

    // Redirect with three requests outstanding on a 3-cycle memory.
    fixed_lat = 3;
    n = 0;
    while (mem_q.size() != 3 && n < 50) begin
      next_cycle();
      n++;
    end
    chk("inflight_before_redirect", 32'(mem_q.size()), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    next_cycle();
    redirect_valid = 1'b0;
    wait_first_pop("redir_100", 32'h0000_0100);

    // Redirect coinciding with a response and a pop; target low bits ignored.
    fixed_lat = 1;
    repeat (10) next_cycle();
    #1;
    n = 0;
    while (!(imem_rsp_valid && if_valid && if_ready) && n < 50) begin
      next_cycle();
      #1;
      n++;
    end
    chk("rsp_pop_setup", 32'(imem_rsp_valid && if_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    next_cycle();
    redirect_valid = 1'b0;
    #2;
    chk("flush_if_valid", 32'(if_valid), 32'd0);
    chk("redir_req_addr", imem_req_addr, 32'h0000_0200);
    chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
    wait_first_pop("redir_200", 32'h0000_0200);

    // Mid-stream reset with two requests in flight.
    fixed_lat      = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    next_cycle();
    redirect_valid = 1'b0;
    n = 0;
    while (mem_q.size() != 2 && n < 50) begin
      next_cycle();
      n++;
    end
    chk("inflight_before_reset", 32'(mem_q.size()), 32'd2);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #2;
    chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_if_pc", if_pc, 32'd0);
    chk("mid_rst_if_instr", if_instr, 32'd0);
    chk("mid_rst_req_addr", imem_req_addr, RESET_PC);
    wait_first_pop("post_reset", RESET_PC);

    // Address wrap at the top of the address space.
    fixed_lat      = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    next_cycle();
    redirect_valid = 1'b0;
    #2;
    chk("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    next_cycle();
    #2;
    chk("wrap_addr_zero", imem_req_addr, 32'h0000_0000);

    // Back-to-back redirects: the last one wins.
    fixed_lat = 2;
    repeat (5) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    next_cycle();
    redirect_pc    = 32'h0000_0400;
    next_cycle();
    redirect_valid = 1'b0;
    wait_first_pop("b2b", 32'h0000_0400);

    // Randomised traffic: stalls, memory back-pressure, latency, redirects, resets.
    fixed_lat = 0;
    for (int i = 0; i < 1500; i++) begin
      next_cycle();
      if_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = $urandom;
      rst_n          = ($urandom_range(0, 299) != 0);
    end
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    repeat (30) next_cycle();
    chk("progress", 32'(pops > 400), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
